gate_response_checker: RTL

- Self-checking stimulus/response engine for the two-input basic-gate block: drives a/b through all four input combinations, samples the seven gate outputs, compares them against golden values and reports pass/fail.
- Sits on the DUT side opposite the hand-written stimulus benches, so gate checks run on hardware or in regression without waveform inspection.

---
 rtl/gate_response_checker.sv | 79 +++++++
 1 files changed

// File: rtl/gate_response_checker.sv
// gate_response_checker: walks a/b through all four input pairs, compares the
// seven gate outputs against golden values and reports per-vector/per-gate results.
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] resp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [6:0] mismatch_bits
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [6:0] golden, diff;
  logic bad;
  // {a,b} doubles as the vector index
  assign golden = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign diff = resp ^ golden;
  assign bad = |diff;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = start ? SETTLE : IDLE;
      SETTLE: state_n = (cnt == 4'd0) ? CHECK : SETTLE;
      CHECK:  state_n = ({a, b} == 2'd3) ? DONE : SETTLE;
      DONE:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= 1'b0;
      b <= 1'b0;
      cnt <= 4'd0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= 3'd0;
      fail_vec <= 4'd0;
      mismatch_bits <= 7'd0;
    end else begin
      state <= state_n;
      busy <= (state_n == SETTLE) || (state_n == CHECK);
      done <= state_n == DONE;
      case (state)
        IDLE: if (start) begin
          {a, b} <= 2'd0;
          cnt <= 4'(SETTLE_CYCLES - 1);
          pass <= 1'b0;
          err_count <= 3'd0;
          fail_vec <= 4'd0;
          mismatch_bits <= 7'd0;
        end
        SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        CHECK: begin
          if (bad) begin
            fail_vec[{a, b}] <= 1'b1;
            err_count <= err_count + 3'd1;
          end
          mismatch_bits <= mismatch_bits | diff;
          if ({a, b} == 2'd3) pass <= (err_count == 3'd0) && !bad;
          else begin
            {a, b} <= {a, b} + 2'd1;
            cnt <= 4'(SETTLE_CYCLES - 1);
          end
        end
        DONE: {a, b} <= 2'd0;
      endcase
    end
  end
endmodule
